// File: rtl/audio_frame_capture_if.sv
// Sample input bus from the PDM decoder and RAM write bus to the frame RAMs.
// slave = capture controller side, master = producer/consumer side.
interface audio_frame_capture_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 10
);
  logic              sample_valid_i;
  logic [DATA_W-1:0] sample_i;
  logic              frame_active_o;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [OUT_W-1:0]  dout_o;

  modport slave (
    input  sample_valid_i, sample_i,
    output frame_active_o, we_o, addr_o, dout_o
  );

  modport master (
    output sample_valid_i, sample_i,
    input  frame_active_o, we_o, addr_o, dout_o
  );
endinterface

// File: rtl/audio_frame_capture.sv
// Audio frame capture: scale, decimate, trigger and write 2**ADDR_W samples.
// Ports: clk, reset_n, start/config inputs, bus (samples in, RAM out), busy_o, frame_done_o.
module audio_frame_capture #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 8,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic [DECIM_W-1:0] decim_i,
  input  logic [2:0]         shift_i,
  input  logic [OUT_W-1:0]   trig_level_i,
  audio_frame_capture_if.slave bus,
  output logic               busy_o,
  output logic               frame_done_o
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  localparam logic signed [OUT_W-1:0] S_MIN =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] S_MAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  state_t state_q, state_d;

  logic [1:0]               mode_q, mode_n;
  logic [DECIM_W-1:0]       decim_q, cnt_q;
  logic [2:0]               shift_q;
  logic signed [OUT_W-1:0]  level_q, prev_q;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic                     done_q;

  logic signed [DATA_W-1:0] shifted;
  logic [DATA_W-OUT_W:0]    top;
  logic signed [OUT_W-1:0]  scaled;
  logic                     take, trig, wr, last;

  assign mode_n = (mode_i == 2'd3) ? 2'd0 : mode_i;

  always_comb begin
    shifted = $signed(bus.sample_i) >>> shift_q;
    top     = shifted[DATA_W-1:OUT_W-1];
    // Fits when all bits above the output sign bit match it.
    if (&top || ~|top)
      scaled = shifted[OUT_W-1:0];
    else if (shifted[DATA_W-1])
      scaled = S_MIN;
    else
      scaled = S_MAX;
  end

  always_comb begin
    take = bus.sample_valid_i && !start_i &&
           (state_q != IDLE) && (cnt_q == '0);
    trig = (state_q == ARM) && take &&
           (prev_q < level_q) && (scaled >= level_q);
    wr   = take && ((state_q == CAPTURE) || trig);
    last = wr && (ptr_q == A_LAST);
    ptr_d = ptr_q;
    if (start_i)
      ptr_d = '0;
    else if (wr)
      ptr_d = ptr_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = (mode_n == 2'd2) ? ARM : CAPTURE;
    end else begin
      case (state_q)
        ARM:     if (trig) state_d = CAPTURE;
        CAPTURE: if (last)
                   state_d = (mode_q == 2'd1) ? CAPTURE : IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= '0;
      decim_q <= '0;
      shift_q <= '0;
      level_q <= '0;
    end else if (start_i) begin
      mode_q  <= mode_n;
      decim_q <= decim_i;
      shift_q <= shift_i;
      level_q <= trig_level_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      prev_q <= '0;
    end else if (start_i) begin
      cnt_q  <= '0;
      prev_q <= S_MIN;
    end else if (bus.sample_valid_i && state_q != IDLE) begin
      cnt_q <= (cnt_q == decim_q) ? '0 : cnt_q + 1'b1;
      if (take && state_q == ARM)
        prev_q <= scaled;
    end
  end

  // Between writes addr_o shows the next free address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      bus.we_o   <= 1'b0;
      bus.addr_o <= '0;
      bus.dout_o <= '0;
      done_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      bus.we_o   <= wr;
      bus.addr_o <= wr ? ptr_q : ptr_d;
      if (wr)
        bus.dout_o <= scaled;
      done_q     <= last;
    end
  end

  // A restart landing on the last write cancels the done pulse.
  assign frame_done_o       = done_q && !start_i;
  assign busy_o             = (state_q != IDLE);
  assign bus.frame_active_o = (state_q == CAPTURE) || bus.we_o;
endmodule

// File: tb/tb_audio_frame_capture.sv
// Scoreboard bench for audio_frame_capture.
// Reference model predicts each RAM write when stimulus is driven.
module tb_audio_frame_capture;
  logic       clk;
  logic       reset_n;
  logic       start_i;
  logic [1:0] mode;
  logic [3:0] decim;
  logic [2:0] shift;
  logic [7:0] level;
  logic       busy_o;
  logic       frame_done_o;

  audio_frame_capture_if #(
    .DATA_W(16), .OUT_W(8), .ADDR_W(10)
  ) bus ();

  audio_frame_capture #(
    .DATA_W(16), .OUT_W(8), .ADDR_W(10), .DECIM_W(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_i      (start_i),
    .mode_i       (mode),
    .decim_i      (decim),
    .shift_i      (shift),
    .trig_level_i (level),
    .bus          (bus.slave),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
    logic       done;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  int m_state, m_mode, m_decim, m_shift;
  int m_level, m_cnt, m_prev, m_addr;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int scale(input logic [15:0] d, input int sh);
    int x;
    x = int'($signed(d));
    x = x >>> sh;
    if (x > 127) x = 127;
    else if (x < -128) x = -128;
    return x;
  endfunction

  task automatic m_reset();
    m_state = 0; m_mode = 0; m_decim = 0; m_shift = 0;
    m_level = 0; m_cnt = 0; m_prev = 0; m_addr = 0;
  endtask

  task automatic push(input int a, input int d, input bit dn);
    exp_t e;
    e.a = 10'(a);
    e.d = 8'(d);
    e.done = dn;
    q.push_back(e);
  endtask

  // States: 0 idle, 1 armed, 2 capturing
  task automatic model(input bit v, input logic [15:0] d,
                       input bit st);
    int s;
    bit acc;
    if (st) begin
      m_mode  = (mode == 2'd3) ? 0 : int'(mode);
      m_decim = int'(decim);
      m_shift = int'(shift);
      m_level = int'($signed(level));
      m_cnt   = 0;
      m_addr  = 0;
      m_prev  = -128;
      m_state = (m_mode == 2) ? 1 : 2;
    end else if (v && m_state != 0) begin
      acc   = (m_cnt == 0);
      m_cnt = (m_cnt == m_decim) ? 0 : m_cnt + 1;
      if (acc) begin
        s = scale(d, m_shift);
        if (m_state == 1) begin
          if (m_prev < m_level && s >= m_level) begin
            push(0, s, 1'b0);
            m_addr  = 1;
            m_state = 2;
          end
          m_prev = s;
        end else begin
          push(m_addr, s, m_addr == 1023);
          if (m_addr == 1023) begin
            m_state = (m_mode == 1) ? 2 : 0;
            m_addr  = 0;
          end else begin
            m_addr = m_addr + 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] d,
                     input bit st);
    @(posedge clk);
    #1;
    bus.sample_valid_i = v;
    bus.sample_i       = d;
    start_i            = st;
    model(v, d, st);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
  endtask

  task automatic go(input logic [1:0] md, input logic [3:0] dc,
                    input logic [2:0] sh, input logic [7:0] lv);
    mode  = md;
    decim = dc;
    shift = sh;
    level = lv;
    cyc(1'b0, 16'h0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_done_o) done_cnt++;
      if (bus.we_o) begin
        if (q.size() == 0) begin
          check("unexpected_we", 32'(bus.addr_o), 32'hFFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("addr", 32'(bus.addr_o), 32'(e.a));
          check("dout", 32'(bus.dout_o), 32'(e.d));
          check("frame_done", 32'(frame_done_o), 32'(e.done));
          check("frame_active", 32'(bus.frame_active_o), 32'd1);
        end
      end else if (frame_done_o) begin
        check("stray_done", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    reset_n = 1'b0;
    start_i = 1'b0;
    mode = '0; decim = '0; shift = '0; level = '0;
    bus.sample_valid_i = 1'b0;
    bus.sample_i = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 32'(bus.we_o), 0);
    check("rst_addr", 32'(bus.addr_o), 0);
    check("rst_dout", 32'(bus.dout_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(frame_done_o), 0);
    check("rst_active", 32'(bus.frame_active_o), 0);
    reset_n = 1'b1;

    // Valid samples in idle do nothing
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(i), 1'b0);
    idle(2);
    check("idle_busy", 32'(busy_o), 0);

    // Ramp, single shot
    d0 = done_cnt;
    go(2'd0, 4'd0, 3'd0, 8'd0);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 16'(i), 1'b0);
    idle(3);
    check("t1_done_cnt", 32'(done_cnt - d0), 1);
    check("t1_busy", 32'(busy_o), 0);
    check("t1_q_empty", 32'(q.size()), 0);

    // Decimation by 4
    d0 = done_cnt;
    go(2'd0, 4'd3, 3'd0, 8'd0);
    for (int i = 0; i < 4096; i++) cyc(1'b1, 16'(i), 1'b0);
    idle(3);
    check("t2_done_cnt", 32'(done_cnt - d0), 1);
    check("t2_busy", 32'(busy_o), 0);
    check("t2_q_empty", 32'(q.size()), 0);

    // Shift and saturation
    go(2'd0, 4'd0, 3'd4, 8'd0);
    cyc(1'b1, 16'h7FFF, 1'b0);
    cyc(1'b1, 16'h8000, 1'b0);
    cyc(1'b1, 16'h0010, 1'b0);
    idle(3);
    check("t3_q_empty", 32'(q.size()), 0);

    // Level trigger
    go(2'd2, 4'd0, 3'd0, 8'd10);
    idle(1);
    check("t4_busy_arm", 32'(busy_o), 1);
    check("t4_inactive_arm", 32'(bus.frame_active_o), 0);
    cyc(1'b1, 16'd5, 1'b0);
    cyc(1'b1, 16'd9, 1'b0);
    cyc(1'b1, 16'd12, 1'b0);
    cyc(1'b1, 16'd3, 1'b0);
    cyc(1'b1, 16'd11, 1'b0);
    idle(3);
    check("t4_busy_cap", 32'(busy_o), 1);
    check("t4_q_empty", 32'(q.size()), 0);

    // Continuous, two full frames plus a few
    d0 = done_cnt;
    go(2'd1, 4'd0, 3'd0, 8'd0);
    for (int i = 0; i < 2053; i++) cyc(1'b1, 16'(i & 127), 1'b0);
    idle(3);
    check("t5_done_cnt", 32'(done_cnt - d0), 2);
    check("t5_busy", 32'(busy_o), 1);
    check("t5_q_empty", 32'(q.size()), 0);

    // Abort at addr 500 with a coincident sample
    d0 = done_cnt;
    go(2'd0, 4'd0, 3'd0, 8'd0);
    for (int i = 0; i < 500; i++) cyc(1'b1, 16'(i), 1'b0);
    cyc(1'b1, 16'd77, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(40 + i), 1'b0);
    idle(3);
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_q_empty", 32'(q.size()), 0);

    // Reset while a write is on the bus
    cyc(1'b1, 16'd55, 1'b0);
    cyc(1'b0, 16'd0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(bus.we_o), 0);
    check("mid_rst_addr", 32'(bus.addr_o), 0);
    check("mid_rst_dout", 32'(bus.dout_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_active", 32'(bus.frame_active_o), 0);
    check("mid_rst_done", 32'(frame_done_o), 0);
    q.delete();
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    check("post_rst_busy", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
